pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Responder end of the 256-bit cache-line physical-memory interface.
- The cache drives pmem_read/pmem_write/pmem_address/pmem_wdata; this block stores lines and returns a one-cycle pmem_resp after a fixed, parameterised latency.
- It is the synthesizable memory-side model used beneath cache in system builds and benches, and is instantiated alongside the cpu/cache top.

Parameters:
- IDX_W, 8, line-index width; storage holds 2**IDX_W lines of 256 bits.
- LATENCY, 4, cycles from request acceptance to pmem_resp; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- pmem_read  input  1  line read request, held by the cache until pmem_resp.
- pmem_write  input  1  line write request, held by the cache until pmem_resp.
- pmem_address  input  32  byte address; bits [4:0] ignored; line index = [IDX_W+4:5].
- pmem_wdata  input  256  write line, stable while pmem_write is high.
- pmem_resp  output  1  one-cycle completion pulse.
- pmem_rdata  output  256  read line; valid in the pmem_resp cycle of a read.
- busy  output  1  high while a request is in flight (BUSY or RESP state).
- proto_err  output  1  sticky flag: read and write were seen simultaneously at acceptance.
- rd_count  output  32  completed reads, wraps at 2**32.
- wr_count  output  32  completed writes, wraps at 2**32.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state goes to IDLE; pmem_resp=0, pmem_rdata=0, busy=0, proto_err=0, rd_count=0, wr_count=0.
  - Storage array contents are NOT cleared.
  - Reset overrides all other activity, including mid-transaction: the in-flight request is dropped, no pmem_resp is issued, and a pending write is not committed.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If pmem_read or pmem_write is high in cycle t, the request is accepted at the end of t.
  - Latched at acceptance: line index, wdata, and op (write if pmem_write, else read).
  - If both are high, the write is serviced and proto_err is set.
  - Latency counter loads LATENCY-1. Next state is BUSY if LATENCY>1, else RESP.
- BUSY:
  - Counter decrements each cycle; at 1, next state is RESP.
  - Request inputs are ignored; the latched values are used.
- RESP:
  - pmem_resp=1 for exactly this cycle, which is cycle t+LATENCY.
  - Read: pmem_rdata = storage[latched index], registered on entry to RESP; rd_count increments at the end of RESP.
  - Write: storage[latched index] is written at the end of RESP; wr_count increments.
  - Next state is always IDLE.
- Back-to-back requests:
  - The cache drops its request on the edge at which it sees pmem_resp.
  - A request present in the cycle after RESP is a new request and is accepted (writeback-then-fill sequence).
  - Minimum spacing between pmem_resp pulses is LATENCY+1 cycles.
- pmem_rdata holds its last value outside RESP; it is not updated by writes.
- Address wrap: index bits above IDX_W+4 are ignored, so aliasing addresses hit the same line.
- Read-after-write to the same line, issued back-to-back, returns the new data (the write commits before the next acceptance).
- busy is combinational from state: 1 in BUSY and RESP, 0 in IDLE.
- proto_err clears only on reset.

Test Plan:
- Reset value check: assert rst_n=0 for 2 cycles, then release -> pmem_resp=0, pmem_rdata=0, busy=0, proto_err=0, rd_count=0, wr_count=0.
- Write then read, LATENCY=4:
  - Write 0x0000_0040 with wdata={8{32'hDEADBEEF}} -> pmem_resp high exactly 4 cycles after acceptance, wr_count=1.
  - Read 0x0000_0040 -> pmem_rdata={8{32'hDEADBEEF}} in its resp cycle, rd_count=1.
- Alias and offset, IDX_W=8: write to 0x0000_2060, then read 0x0000_0067 -> same data returned (offset bits ignored, index 3 aliased).
- Writeback-then-fill back-to-back:
  - Write line A; the cache raises read of line B in the cycle after the write's resp.
  - Required: read accepted immediately; second resp 5 cycles after the first resp; both counters equal 1.
- Reset mid-write:
  - Write 0x80 with data X; assert rst_n=0 two cycles after acceptance.
  - Required: no pmem_resp; busy=0 the cycle after reset; a later read of 0x80 returns the prior contents, not X; wr_count=0.
- Protocol error and LATENCY=1:
  - Raise read and write together with wdata=256'h1 at 0x100 -> proto_err=1 (sticky), resp 1 cycle after acceptance.
  - A subsequent read of 0x100 returns 256'h1.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the 256-bit cache-line pmem interface.
// Stores 2**IDX_W lines and answers each accepted request with a one-cycle pmem_resp LATENCY cycles later.
module pmem_line_responder #(
  parameter int IDX_W   = 8,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         busy,
  output logic         proto_err,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [255:0]     r_mem [2**IDX_W];
  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [255:0]     r_wdata;
  logic             r_op_wr;
  logic             r_resp;
  logic [255:0]     r_rdata;
  logic             r_proto;
  logic [31:0]      r_rd_count;
  logic [31:0]      r_wr_count;

  logic             w_req;
  logic [IDX_W-1:0] w_in_idx;
  logic             w_to_resp;
  logic             w_rd_op;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_unused;

  assign w_req    = pmem_read | pmem_write;
  assign w_in_idx = pmem_address[IDX_W+4:5];
  assign w_unused = ^{pmem_address[31:IDX_W+5], pmem_address[4:0]};

  // With LATENCY==1 RESP is entered straight from IDLE, so the read line comes from the live request.
  assign w_to_resp = ((r_state == IDLE) && w_req && (LATENCY == 1)) ||
                     ((r_state == BUSY) && (r_cnt == 8'd1));
  assign w_rd_op   = (r_state == IDLE) ? !pmem_write : !r_op_wr;
  assign w_rd_idx  = (r_state == IDLE) ? w_in_idx : r_idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_op_wr    <= 1'b0;
      r_resp     <= 1'b0;
      r_rdata    <= '0;
      r_proto    <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_resp <= w_to_resp;
      if (w_to_resp && w_rd_op) r_rdata <= r_mem[w_rd_idx];
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= w_in_idx;
            r_wdata <= pmem_wdata;
            r_op_wr <= pmem_write;
            r_cnt   <= LAT_M1;
            if (pmem_read && pmem_write) r_proto <= 1'b1;
            r_state <= (LATENCY > 1) ? BUSY : RESP;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) r_state <= RESP;
        end
        RESP: begin
          if (r_op_wr) r_wr_count <= r_wr_count + 32'd1;
          else         r_rd_count <= r_rd_count + 32'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the line store has no reset; contents survive rst_n, and an aborted write is never committed.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == RESP) && r_op_wr) r_mem[r_idx] <= r_wdata;
  end

  assign pmem_resp  = r_resp;
  assign pmem_rdata = r_rdata;
  assign busy       = (r_state != IDLE);
  assign proto_err  = r_proto;
  assign rd_count   = r_rd_count;
  assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench: unit 0 runs LATENCY=4, unit 1 runs LATENCY=1; a line-array model predicts every response.
module tb_pmem_line_responder;

  localparam int LAT0   = 4;
  localparam int LAT1   = 1;
  localparam int NLINES = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         rd [2];
  logic         wr [2];
  logic [31:0]  addr [2];
  logic [255:0] wdata [2];
  logic         resp [2];
  logic [255:0] rdata [2];
  logic         busy [2];
  logic         perr [2];
  logic [31:0]  rdc [2];
  logic [31:0]  wrc [2];

  pmem_line_responder #(.IDX_W(8), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_address(addr[0]), .pmem_wdata(wdata[0]), .pmem_resp(resp[0]),
    .pmem_rdata(rdata[0]), .busy(busy[0]), .proto_err(perr[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0]));

  pmem_line_responder #(.IDX_W(8), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_address(addr[1]), .pmem_wdata(wdata[1]), .pmem_resp(resp[1]),
    .pmem_rdata(rdata[1]), .busy(busy[1]), .proto_err(perr[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1]));

  typedef struct {
    int unsigned  cyc;
    bit           is_rd;
    logic [255:0] data;
    int unsigned  rdc;
    int unsigned  wrc;
    bit           perr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int           lat [2] = '{LAT0, LAT1};
  logic [255:0] m_mem [2][NLINES];
  bit           m_val [2][NLINES];
  int unsigned  m_rdc [2];
  int unsigned  m_wrc [2];
  bit           m_perr [2];

  int unsigned  cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  bit           pend [2];
  exp_t         pend_e [2];
  int unsigned  last_resp [2];
  int unsigned  prev_resp [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(int u);
    exp_t e;
    if (pend[u]) begin
      pend[u] = 1'b0;
      e = pend_e[u];
      check("rd_count", rdc[u], e.rdc);
      check("wr_count", wrc[u], e.wrc);
      check("proto_err", perr[u], e.perr);
    end
    if (resp[u] === 1'b1) begin
      prev_resp[u] = last_resp[u];
      last_resp[u] = cyc;
      if ((u == 0 ? q0.size() : q1.size()) == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: unit %0d got resp at cycle %0d, expected none", u, cyc);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("busy_in_resp", busy[u], 1);
        if (e.is_rd) check("rdata", rdata[u], e.data);
        pend[u]   = 1'b1;
        pend_e[u] = e;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // Called just after a rising edge while the unit is idle; predicts the response and raises the request.
  task automatic issue(int u, bit r, bit w, logic [31:0] a, logic [255:0] d);
    exp_t e;
    int idx;
    idx     = int'((a >> 5) % NLINES);
    e.cyc   = cyc + lat[u];
    e.is_rd = !w;
    e.data  = m_mem[u][idx];
    if (w) begin
      m_mem[u][idx] = d;
      m_val[u][idx] = 1'b1;
      m_wrc[u]++;
    end else begin
      m_rdc[u]++;
    end
    if (r && w) m_perr[u] = 1'b1;
    e.rdc  = m_rdc[u];
    e.wrc  = m_wrc[u];
    e.perr = m_perr[u];
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
    rd[u]    = r;
    wr[u]    = w;
    addr[u]  = a;
    wdata[u] = d;
  endtask

  task automatic wait_resp(int u);
    bit got = 1'b0;
    for (int i = 0; i < lat[u] + 6 && !got; i++) begin
      @(negedge clk);
      if (resp[u] === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: unit %0d no resp by cycle %0d", u, cyc);
    end
    @(posedge clk);
    #1;
    rd[u] = 1'b0;
    wr[u] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0;
      wr[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      m_rdc[u]  = 0;
      m_wrc[u]  = 0;
      m_perr[u] = 1'b0;
      pend[u]   = 1'b0;
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [255:0] d;
    logic [31:0]  hi;
    int           line;
    int           op;

    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0;
      wr[u] = 1'b0;
      addr[u] = '0;
      wdata[u] = '0;
    end

    // Reset values on both units.
    @(posedge clk);
    #1;
    do_reset();
    for (int u = 0; u < 2; u++) begin
      check("rst_resp", resp[u], 0);
      check("rst_rdata", rdata[u], 0);
      check("rst_busy", busy[u], 0);
      check("rst_proto_err", perr[u], 0);
      check("rst_rd_count", rdc[u], 0);
      check("rst_wr_count", wrc[u], 0);
    end

    // Write then read the same line.
    issue(0, 1'b0, 1'b1, 32'h0000_0040, {8{32'hDEADBEEF}});
    wait_resp(0);
    issue(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    wait_resp(0);

    // Offset bits ignored and upper index bits aliased: both addresses map to line 3.
    issue(0, 1'b0, 1'b1, 32'h0000_2060, rand_line());
    wait_resp(0);
    repeat (2) begin @(posedge clk); #1; end
    issue(0, 1'b1, 1'b0, 32'h0000_0067, '0);
    wait_resp(0);

    // Known contents at 0x80, then a write aborted by reset two cycles after acceptance.
    issue(0, 1'b0, 1'b1, 32'h0000_0080, rand_line());
    wait_resp(0);
    wr[0] = 1'b1;
    addr[0] = 32'h0000_0080;
    wdata[0] = rand_line();
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    check("abort_busy", busy[0], 0);
    check("abort_wr_count", wrc[0], 0);
    issue(0, 1'b1, 1'b0, 32'h0000_0080, '0);
    wait_resp(0);

    // Writeback-then-fill with the fill raised in the cycle right after the write's resp.
    do_reset();
    issue(0, 1'b0, 1'b1, 32'h0000_1000, rand_line());
    wait_resp(0);
    issue(0, 1'b1, 1'b0, 32'h0000_2060, '0);
    wait_resp(0);
    check("b2b_spacing", last_resp[0] - prev_resp[0], LAT0 + 1);

    // Randomised traffic with mixed gaps, aliasing upper address bits and occasional read+write.
    for (int n = 0; n < 40; n++) begin
      line = ($urandom_range(0, 15) * 17) % NLINES;
      hi   = $urandom;
      op   = $urandom_range(0, 9);
      if (op < 8 && op >= 4 && !m_val[0][line]) op = 0;
      d    = rand_line();
      if (op < 4)      issue(0, 1'b0, 1'b1, (hi & 32'hFFFF_E01F) | (32'(line) << 5), d);
      else if (op < 9) issue(0, 1'b1, 1'b0, (hi & 32'hFFFF_E01F) | (32'(line) << 5), '0);
      else             issue(0, 1'b1, 1'b1, (hi & 32'hFFFF_E01F) | (32'(line) << 5), d);
      wait_resp(0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // LATENCY=1 unit: simultaneous read+write is serviced as a write and flags proto_err.
    issue(1, 1'b1, 1'b1, 32'h0000_0100, 256'h1);
    wait_resp(1);
    issue(1, 1'b1, 1'b0, 32'h0000_0100, '0);
    wait_resp(1);
    issue(1, 1'b0, 1'b1, 32'h0000_0200, rand_line());
    wait_resp(1);
    issue(1, 1'b1, 1'b0, 32'h0000_0200, '0);
    wait_resp(1);
    @(negedge clk);
    check("proto_sticky", perr[1], 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
